// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants for the emulated PET keyboard matrix
package kbd_pkg;
    localparam logic [15:0] KBD_BASE_ADDR = 16'hE800;
    localparam int          KBD_NUM_ROWS  = 10;
    localparam logic [1:0]  PIA_PORTA     = 2'd0;
    localparam logic [1:0]  PIA_PORTB     = 2'd2;
    localparam logic [7:0]  KBD_NO_KEYS   = 8'hFF;
endpackage

// File: rtl/kbd_matrix_ram.sv
// rtl/kbd_matrix_ram.sv - NUM_ROWS x 8 keyboard row register file, sync write, async read
module kbd_matrix_ram
    import kbd_pkg::*;
#(
    parameter int NUM_ROWS = KBD_NUM_ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] rows [NUM_ROWS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (reset) begin
                rows[i] <= KBD_NO_KEYS;
            end else if (we && ({1'b0, waddr} == 5'(i))) begin
                rows[i] <= wdata;
            end
        end
    end

    // Rows beyond the populated matrix read as "no keys pressed".
    always_comb begin
        rdata = KBD_NO_KEYS;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if ({1'b0, raddr} == 5'(i)) begin
                rdata = rows[i];
            end
        end
    end
endmodule

// File: rtl/pet_keyboard.sv
// rtl/pet_keyboard.sv - PET keyboard matrix behind PIA1; KBD_PORTA_READBACK_EN adds port A readback
module pet_keyboard
    import kbd_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = KBD_BASE_ADDR,
    parameter int          NUM_ROWS  = KBD_NUM_ROWS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pi_addr,
    input  logic [7:0]  pi_data,
    input  logic        pi_write_strobe,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_rw_b,
    input  logic        io_select,
    input  logic        cpu_write_strobe,
    input  logic        pia1_enabled_in,
    output logic [7:0]  kbd_data_out,
    output logic        kbd_enable
);
    logic [3:0]  row_select;
    logic [15:0] pi_offset;
    logic        pi_hit;
    logic        sel_write;
    logic        pia_read;
    logic [7:0]  row_data;
    logic        unused_data_hi;

    // Offset compare avoids 16-bit wraparound when BASE_ADDR sits near the top of memory.
    assign pi_offset = pi_addr - BASE_ADDR;
    assign pi_hit    = pi_write_strobe && (pi_addr >= BASE_ADDR)
                       && (pi_offset < 16'(NUM_ROWS));

    assign sel_write = cpu_write_strobe && io_select && pia1_enabled_in && !bus_rw_b
                       && (bus_addr == PIA_PORTA);
    assign pia_read  = io_select && pia1_enabled_in && bus_rw_b;

    assign unused_data_hi = ^bus_data_in[7:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            row_select <= 4'd0;
        end else if (sel_write) begin
            row_select <= bus_data_in[3:0];
        end
    end

    kbd_matrix_ram #(
        .NUM_ROWS (NUM_ROWS)
    ) u_matrix (
        .clk   (clk),
        .reset (reset),
        .we    (pi_hit),
        .waddr (pi_offset[3:0]),
        .wdata (pi_data),
        .raddr (row_select),
        .rdata (row_data)
    );

    always_comb begin
        kbd_enable   = pia_read && (bus_addr == PIA_PORTB);
        kbd_data_out = row_data;
`ifdef KBD_PORTA_READBACK_EN
        if (pia_read && (bus_addr == PIA_PORTA)) begin
            kbd_enable   = 1'b1;
            kbd_data_out = {4'h0, row_select};
        end
`endif
    end
endmodule

// File: tb/tb_pet_keyboard.sv
// tb/tb_pet_keyboard.sv - directed self-checking bench for pet_keyboard
module tb_pet_keyboard;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pi_addr;
    logic [7:0]  pi_data;
    logic        pi_write_strobe;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_data_in;
    logic        bus_rw_b;
    logic        io_select;
    logic        cpu_write_strobe;
    logic        pia1_enabled_in;
    logic [7:0]  kbd_data_out;
    logic        kbd_enable;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_rows [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    always #5 clk = ~clk;

    pet_keyboard dut (
        .clk              (clk),
        .reset            (reset),
        .pi_addr          (pi_addr),
        .pi_data          (pi_data),
        .pi_write_strobe  (pi_write_strobe),
        .bus_addr         (bus_addr),
        .bus_data_in      (bus_data_in),
        .bus_rw_b         (bus_rw_b),
        .io_select        (io_select),
        .cpu_write_strobe (cpu_write_strobe),
        .pia1_enabled_in  (pia1_enabled_in),
        .kbd_data_out     (kbd_data_out),
        .kbd_enable       (kbd_enable)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {en,data}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pi_write_strobe  = 1'b0;
        cpu_write_strobe = 1'b0;
        io_select        = 1'b0;
        pia1_enabled_in  = 1'b0;
        bus_rw_b         = 1'b1;
        bus_addr         = 2'd1;
        bus_data_in      = 8'h00;
        pi_addr          = 16'h0000;
        pi_data          = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pi_write(input logic [15:0] a, input logic [7:0] d);
        pi_addr = a; pi_data = d; pi_write_strobe = 1'b1;
        tick();
        idle();
    endtask

    task automatic cpu_select(input logic [7:0] d);
        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b0;
        bus_addr = 2'd0; bus_data_in = d; cpu_write_strobe = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_b(input string tag, input logic [7:0] exp);
        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b1; bus_addr = 2'd2;
        #1;
        check(tag, {kbd_enable, kbd_data_out}, {1'b1, exp});
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        read_b("reset_row0", 8'hFF);
        cpu_select(8'h03);
        read_b("reset_row3", 8'hFF);

        for (int r = 0; r < 10; r++) pi_write(16'hE800 + 16'(r), 8'h01 << (r % 8));
        for (int r = 0; r < 10; r++) begin
            cpu_select(8'(r));
            read_b($sformatf("row%0d", r), exp_rows[r]);
        end

        pi_write(16'hE80A, 8'h00);
        pi_write(16'hE7FF, 8'h00);
        for (int r = 0; r < 10; r++) begin
            cpu_select(8'(r));
            read_b($sformatf("oob_keep%0d", r), exp_rows[r]);
        end
        for (int r = 10; r < 16; r++) begin
            cpu_select(8'(r));
            read_b($sformatf("sel_oob%0d", r), 8'hFF);
        end

        io_select = 1'b1; pia1_enabled_in = 1'b0; bus_rw_b = 1'b1; bus_addr = 2'd2; #1;
        check("no_pia1", {8'h00, kbd_enable}, 9'h000);
        io_select = 1'b0; pia1_enabled_in = 1'b1; #1;
        check("no_io", {8'h00, kbd_enable}, 9'h000);
        io_select = 1'b1; bus_rw_b = 1'b0; #1;
        check("write_cyc", {8'h00, kbd_enable}, 9'h000);
        bus_rw_b = 1'b1; bus_addr = 2'd3; #1;
        check("reg3", {8'h00, kbd_enable}, 9'h000);
        idle();

        cpu_select(8'hF5);
        read_b("sel_f5", 8'h20);

        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b1; bus_addr = 2'd2;
        pi_addr = 16'hE805; pi_data = 8'h5A; pi_write_strobe = 1'b1;
        #1;
        check("same_cyc_old", {kbd_enable, kbd_data_out}, 9'h120);
        tick();
        pi_write_strobe = 1'b0;
        check("next_cyc_new", {kbd_enable, kbd_data_out}, 9'h15A);
        idle();

        pi_addr = 16'hE802; pi_data = 8'hC3; pi_write_strobe = 1'b1;
        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b0;
        bus_addr = 2'd0; bus_data_in = 8'h02; cpu_write_strobe = 1'b1;
        tick();
        idle();
        read_b("dual_write", 8'hC3);

        cpu_select(8'h07);
        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b1; bus_addr = 2'd0; #1;
`ifdef KBD_PORTA_READBACK_EN
        check("porta_read", {kbd_enable, kbd_data_out}, 9'h107);
`else
        check("porta_read", {8'h00, kbd_enable}, 9'h000);
`endif
        idle();

        reset = 1'b1;
        pi_addr = 16'hE800; pi_data = 8'h00; pi_write_strobe = 1'b1;
        io_select = 1'b1; pia1_enabled_in = 1'b1; bus_rw_b = 1'b0;
        bus_addr = 2'd0; bus_data_in = 8'h04; cpu_write_strobe = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        read_b("rst_prio_row0", 8'hFF);
        cpu_select(8'h04);
        read_b("rst_prio_row4", 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
